// File: rtl/divide_tokens.sv
// divide_tokens: per-channel token divider. Every N-th '1' token seen on a[i]
// is passed to b[i] with zero latency. Each channel keeps its own independent
// phase counter. N is a runtime divisor captured by a load pulse.
//
// Optional feature: define DIVIDE_TOKENS_STATS_EN to build a 16-bit
// saturating counter of all emitted tokens on pass_cnt. When the macro is
// undefined, pass_cnt is tied to zero.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous, active-high reset (div_q=2, phases and stats cleared)
//   a        - incoming tokens, one bit per channel
//   div      - requested divisor, captured when load=1
//   load     - apply div and restart every channel phase
//   b        - outgoing tokens (combinational from a and current state)
//   div_q    - divisor currently in effect
//   pass_cnt - saturating count of emitted tokens (0 when stats are disabled)
module divide_tokens #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a,
  input  logic [DIV_W-1:0]    div,
  input  logic                load,
  output logic [CHANNELS-1:0] b,
  output logic [DIV_W-1:0]    div_q,
  output logic [15:0]         pass_cnt
);

  logic [DIV_W-1:0] cnt_q [CHANNELS];
  logic             passthru;
  logic [DIV_W-1:0] last_phase;

  // Divisors 0 and 1 both mean "emit every token".
  assign passthru   = (div_q < DIV_W'(2));
  assign last_phase = div_q - DIV_W'(1);

  // In the load cycle this still uses the old div_q and old phase.
  always_comb begin
    b = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      b[i] = passthru ? a[i] : (a[i] && (cnt_q[i] == last_phase));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_W'(2);
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (load) begin
      // A token in the load cycle is not counted toward the new phase.
      div_q <= div;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (!passthru) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (a[i]) begin
          cnt_q[i] <= (cnt_q[i] == last_phase) ? '0 : cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

`ifdef DIVIDE_TOKENS_STATS_EN
  logic [4:0]  emit_cnt;
  logic [16:0] pass_sum;
  logic [15:0] pass_q;

  always_comb begin
    emit_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      emit_cnt = emit_cnt + 5'(b[i]);
    end
  end

  assign pass_sum = {1'b0, pass_q} + 17'(emit_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= '0;
    end else if (load) begin
      pass_q <= '0;
    end else begin
      pass_q <= pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
    end
  end

  assign pass_cnt = pass_q;
`else
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_divide_tokens.sv
// Scoreboard bench for divide_tokens. The stimulus process drives inputs on
// the falling edge, computes the expected outputs from a token-counting
// reference model and queues them. A monitor pops and compares them 3 time
// units later, just before the rising edge.
module tb_divide_tokens;
  localparam int unsigned CH = 4;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [CH-1:0] a;
  logic [CH-1:0] b;
  logic [DW-1:0] div;
  logic [DW-1:0] div_q;
  logic [15:0]   pass_cnt;

  always #5 clk = ~clk;

  divide_tokens #(
    .CHANNELS(CH),
    .DIV_W   (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .div     (div),
    .load    (load),
    .b       (b),
    .div_q   (div_q),
    .pass_cnt(pass_cnt)
  );

  typedef struct packed {
    logic [CH-1:0] b;
    logic [DW-1:0] dq;
    logic [15:0]   pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: tokens seen per channel since the last restart.
  int tok[CH];
  int m_div  = 2;
  int m_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus plus its expected outputs.
  task automatic cycle(input logic r, input logic [CH-1:0] av, input logic ld,
                       input logic [DW-1:0] dv);
    exp_t e;
    int   n;
    @(negedge clk);
    rst  = r;
    a    = av;
    load = ld;
    div  = dv;
    if (r) begin
      m_div  = 2;
      m_pass = 0;
      foreach (tok[i]) tok[i] = 0;
    end
    e.dq = DW'(m_div);
    e.b  = '0;
    n    = 0;
    for (int i = 0; i < CH; i++) begin
      if (!r && av[i]) begin
        if (m_div < 2) e.b[i] = 1'b1;
        else if ((tok[i] + 1) % m_div == 0) e.b[i] = 1'b1;
        if (e.b[i]) n++;
      end
    end
    e.pc = 16'(m_pass);
    exp_q.push_back(e);
    if (!r) begin
      if (ld) begin
        m_div  = int'(dv);
        m_pass = 0;
        foreach (tok[i]) tok[i] = 0;
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (av[i] && m_div >= 2) tok[i]++;
        end
`ifdef DIVIDE_TOKENS_STATS_EN
        m_pass = (m_pass + n > 65535) ? 65535 : m_pass + n;
`endif
      end
    end
  endtask

  // Monitor: b is valid every cycle once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("b", 32'(b), 32'(e.b));
        chk("div_q", 32'(div_q), 32'(e.dq));
        chk("pass_cnt", 32'(pass_cnt), 32'(e.pc));
      end
    end
  end

  logic [15:0] stream = 16'b1100_1110_1000_1111;

  initial begin
    rst  = 1'b1;
    a    = '0;
    load = 1'b0;
    div  = '0;
    // Reset with tokens present: b must stay 0.
    repeat (2) cycle(1'b1, 4'hF, 1'b0, 4'd0);

    // Halving default on a single channel.
    for (int i = 15; i >= 0; i--) cycle(1'b0, {3'b000, stream[i]}, 1'b0, 4'd0);

    // Divide by 3 on channel 0.
    cycle(1'b0, 4'h0, 1'b1, 4'd3);
    repeat (9) cycle(1'b0, 4'h1, 1'b0, 4'd0);

    // Pass-through divisors 1 and 0.
    cycle(1'b0, 4'b1011, 1'b1, 4'd1);
    repeat (4) cycle(1'b0, 4'b1011, 1'b0, 4'd0);
    cycle(1'b0, 4'b1011, 1'b1, 4'd0);
    repeat (4) cycle(1'b0, 4'b1011, 1'b0, 4'd0);

    // Load divisor 4 mid-phase; the load-cycle token follows the old phase.
    cycle(1'b0, 4'h0, 1'b1, 4'd3);
    repeat (2) cycle(1'b0, 4'b0101, 1'b0, 4'd0);
    cycle(1'b0, 4'b0100, 1'b1, 4'd4);
    repeat (9) cycle(1'b0, 4'b0101, 1'b0, 4'd0);

    // Reset mid-stream with channel 1 at phase 2 of 3.
    cycle(1'b0, 4'h0, 1'b1, 4'd3);
    repeat (2) cycle(1'b0, 4'b0010, 1'b0, 4'd0);
    repeat (2) cycle(1'b1, 4'hF, 1'b0, 4'd0);
    repeat (6) cycle(1'b0, 4'b0010, 1'b0, 4'd0);

    // Maximum divisor wraps cleanly.
    cycle(1'b0, 4'h0, 1'b1, 4'd15);
    repeat (32) cycle(1'b0, 4'hF, 1'b0, 4'd0);

    // Randomised traffic with occasional loads and resets.
    for (int k = 0; k < 800; k++) begin
      logic r;
      logic ld;
      r  = ($urandom_range(99) == 0);
      ld = ($urandom_range(19) == 0);
      cycle(r, CH'($urandom), ld, DW'($urandom));
    end

`ifdef DIVIDE_TOKENS_STATS_EN
    // Saturate the emitted-token counter, then clear it by load.
    cycle(1'b0, 4'h0, 1'b1, 4'd2);
    repeat (40000) cycle(1'b0, 4'hF, 1'b0, 4'd0);
    cycle(1'b0, 4'h0, 1'b1, 4'd2);
    repeat (2) cycle(1'b0, 4'h0, 1'b0, 4'd0);
`endif

    cycle(1'b0, 4'h0, 1'b0, 4'd0);
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divide_tokens.md
DIVIDE_TOKENS -- requirements
Module: divide_tokens

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent token channels (1..16).
REQ-002 Parameter DIV_W, default 4: width of the runtime divisor and of each per-channel phase counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 a  input  CHANNELS  incoming '1' tokens, one bit per channel, sampled every cycle.
REQ-006 div  input  DIV_W  requested divisor N; captured only when load=1.
REQ-007 load  input  1  apply div and restart all channel phases.
REQ-008 b  output  CHANNELS  outgoing tokens; b[i]=1 for every N-th token on a[i].
REQ-009 div_q  output  DIV_W  divisor currently in effect (registered).
REQ-010 pass_cnt  output  16  saturating count of all tokens emitted on b (see Configuration).

Function
REQ-011 Each channel i SHALL hold a phase counter cnt[i] (DIV_W bits) counting tokens since its last emitted token.
REQ-012 b[i] SHALL be combinational, with zero latency: b[i] = a[i] AND (cnt[i] == eff-1), where eff = div_q when div_q >= 2.
REQ-013 When div_q is 0 or 1, b SHALL equal a (pass-through), and the counters SHALL stay at 0.
REQ-014 On a cycle with a[i]=1 and load=0, cnt[i] SHALL increment, or wrap to 0 when cnt[i] == eff-1.
REQ-015 On a cycle with a[i]=0 and load=0, cnt[i] SHALL hold.
REQ-016 Channels SHALL be fully independent; tokens on one channel SHALL never affect the phase of another channel.
REQ-017 On a cycle with load=1, div_q SHALL take div at the next edge and all cnt[i] SHALL clear to 0.
REQ-018 In the load cycle, b SHALL still be computed from the old div_q and old cnt.
REQ-019 A token arriving in the load cycle SHALL be output per REQ-018 but SHALL NOT be counted toward the new phase.
REQ-020 Consequence for div_q=N>=2 after load or reset: the first emitted token SHALL be the N-th token received, then every N-th after that.
REQ-021 Every maximum-valued DIV_W divisor SHALL be legal, with counter wrap at eff-1 and no overflow.

Reset
REQ-022 While rst=1: all cnt[i]=0, div_q=2 (the halving default), pass_cnt=0.
REQ-023 b SHALL follow REQ-012 with cnt=0 while rst=1, so b=0 during reset.
REQ-024 Reset asserted mid-stream SHALL discard the phase immediately (asynchronously); the first token after release SHALL obey REQ-020.

Configuration
REQ-025 Macro DIVIDE_TOKENS_STATS_EN defined: pass_cnt SHALL add popcount(b) each cycle, saturate at 16'hFFFF, and clear on rst or load.
REQ-026 Macro DIVIDE_TOKENS_STATS_EN undefined: pass_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-027 After reset (div_q=2), CHANNELS=1, a = 110_011_101_000_1111 -> b = 010_001_001_000_0101.
REQ-028 Load div=3, then drive a[0]=1 for 9 cycles -> b[0] pulses on the 3rd, 6th and 9th cycles only.
REQ-029 Load div=1 and then div=0, with a=4'b1011 held -> b=4'b1011 every cycle and cnt stays 0.
REQ-030 Load div=4 while a[2] carries tokens each cycle, and a[0] has 2 prior tokens -> both restart, and the first b pulse on each is the 4th token after the load cycle; the load-cycle token is emitted per old state.
REQ-031 Reset asserted mid-stream with div=3 and cnt[1]=2 -> b=0 during reset; after release, a[1] tokens pass on the 2nd, 4th, ... token (div_q=2).
REQ-032 With DIVIDE_TOKENS_STATS_EN defined, div=2 and a=4'hF for 40000 cycles -> pass_cnt saturates at 16'hFFFF; load -> pass_cnt=0 on the next cycle.
